// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and coordinate types
package vga_timing_pkg;
  localparam int DEF_WIDTH   = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_HEIGHT  = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_H_TOTAL = DEF_WIDTH + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_HEIGHT + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  typedef logic [9:0] count_t;
  typedef logic [9:0] x_t;
  typedef logic [8:0] y_t;
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing outputs; frameCount exists only with VGA_TIMING_FRAME_COUNT_EN
interface vga_timing_if;
  import vga_timing_pkg::*;
  logic screenEnd;
  logic active;
  logic hSync;
  logic vSync;
  x_t x;
  y_t y;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frameCount;
  modport master (output screenEnd, active, hSync, vSync, x, y, frameCount);
  modport slave (input screenEnd, active, hSync, vSync, x, y, frameCount);
`else
  modport master (output screenEnd, active, hSync, vSync, x, y);
  modport slave (input screenEnd, active, hSync, vSync, x, y);
`endif
endinterface

// File: rtl/vga_line_counter.sv
// vga_line_counter: modulo-N counter with sync reset, enable and wrap pulse
module vga_line_counter
  import vga_timing_pkg::*;
#(
  parameter int N = 800
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output count_t count,
  output logic   wrap
);
  localparam count_t LAST = count_t'(N - 1);
  assign wrap = en && count == LAST;
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (en) count <= wrap ? '0 : count + 10'd1;
endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: VGA raster timing; VGA_TIMING_FRAME_COUNT_EN adds a 16-bit frameCount
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK
) (
  input logic clk25,
  input logic reset,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam count_t W_C = count_t'(WIDTH);
  localparam count_t H_C = count_t'(HEIGHT);
  localparam count_t HS_START = count_t'(WIDTH + H_FRONT);
  localparam count_t HS_END = count_t'(WIDTH + H_FRONT + H_SYNC);
  localparam count_t VS_START = count_t'(HEIGHT + V_FRONT);
  localparam count_t VS_END = count_t'(HEIGHT + V_FRONT + V_SYNC);
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_range
    $error("vga_timing_generator: timing totals exceed 10-bit counters");
  end
  count_t hCount, vCount;
  logic hWrap, unusedWrap, act, se;
  vga_line_counter #(.N(H_TOTAL)) hCounter (
    .clk(clk25), .rst(reset), .en(1'b1), .count(hCount), .wrap(hWrap)
  );
  vga_line_counter #(.N(V_TOTAL)) vCounter (
    .clk(clk25), .rst(reset), .en(hWrap), .count(vCount), .wrap(unusedWrap)
  );
  assign act = hCount < W_C && vCount < H_C;
  assign se = hCount == '0 && vCount == H_C;
  // Coordinates are forced to 0 in blanking so address math stays in range
  always_comb begin
    vga.active = act;
    vga.screenEnd = se;
    vga.hSync = !(hCount >= HS_START && hCount < HS_END);
    vga.vSync = !(vCount >= VS_START && vCount < VS_END);
    vga.x = act ? hCount : '0;
    vga.y = act ? vCount[8:0] : '0;
  end
`ifdef VGA_TIMING_FRAME_COUNT_EN
  always_ff @(posedge clk25)
    if (reset) vga.frameCount <= '0;
    else if (se) vga.frameCount <= vga.frameCount + 16'd1;
`endif
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: directed checks on a default-timing DUT and a shrunken-timing DUT
module tb_vga_timing_generator;
  logic clk25 = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cycB = 0;
  bit mon = 1'b0;
  always #20 clk25 = ~clk25;
  vga_timing_if vA ();
  vga_timing_if vB ();
  vga_timing_generator dutA (.clk25(clk25), .reset(reset), .vga(vA));
  // Small timing: H_TOTAL=15, V_TOTAL=11, frame=165, screenEnd at cycle 90
  vga_timing_generator #(
    .WIDTH(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .HEIGHT(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1)
  ) dutB (.clk25(clk25), .reset(reset), .vga(vB));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic to(input int t);
    while (cyc < t) begin
      @(posedge clk25);
      #1;
      cyc++;
    end
  endtask
  always @(posedge clk25) cycB <= reset ? 0 : cycB + 1;
  always @(negedge clk25)
    if (mon) begin
      chk("B_screenEnd_only_at_boundary", vB.screenEnd, (cycB % 165) == 90);
      chk("A_screenEnd_idle", vA.screenEnd, 1'b0);
      chk("A_vSync_idle", vA.vSync, 1'b1);
    end
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk25);
    #1;
    reset = 1'b0;
    cyc = 0;
    mon = 1'b1;
    chk("A_rst_x", vA.x, 0);
    chk("A_rst_y", vA.y, 0);
    chk("A_rst_active", vA.active, 1);
    chk("A_rst_hSync", vA.hSync, 1);
    chk("A_rst_vSync", vA.vSync, 1);
    chk("A_rst_screenEnd", vA.screenEnd, 0);
    chk("B_rst_active", vB.active, 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("B_rst_frameCount", vB.frameCount, 0);
`endif
    to(9);   chk("B_hSync_9", vB.hSync, 1);
    to(10);  chk("B_hSync_10", vB.hSync, 0);
    to(12);  chk("B_hSync_12", vB.hSync, 0);
    to(13);  chk("B_hSync_13", vB.hSync, 1);
    to(75);  chk("B_y_last_line", vB.y, 5); chk("B_x_75", vB.x, 0);
    to(82);  chk("B_x_7", vB.x, 7); chk("B_active_82", vB.active, 1);
    to(83);  chk("B_active_83", vB.active, 0); chk("B_x_83", vB.x, 0); chk("B_y_83", vB.y, 0);
    to(89);  chk("B_se_89", vB.screenEnd, 0);
    to(90);  chk("B_se_90", vB.screenEnd, 1); chk("B_active_90", vB.active, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("B_fc_90", vB.frameCount, 0);
`endif
    to(91);  chk("B_se_91", vB.screenEnd, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("B_fc_91", vB.frameCount, 1);
`endif
    to(119); chk("B_vSync_119", vB.vSync, 1);
    to(120); chk("B_vSync_120", vB.vSync, 0);
    to(149); chk("B_vSync_149", vB.vSync, 0);
    to(150); chk("B_vSync_150", vB.vSync, 1);
    to(165); chk("B_frame_x", vB.x, 0); chk("B_frame_y", vB.y, 0); chk("B_frame_active", vB.active, 1);
    to(255); chk("B_se_255", vB.screenEnd, 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    to(256); chk("B_fc_256", vB.frameCount, 2);
    to(421); chk("B_fc_421", vB.frameCount, 3);
`endif
    to(639); chk("A_x_639", vA.x, 639); chk("A_active_639", vA.active, 1);
    to(640); chk("A_active_640", vA.active, 0); chk("A_x_640", vA.x, 0);
    to(655); chk("A_hSync_655", vA.hSync, 1);
    to(656); chk("A_hSync_656", vA.hSync, 0);
    to(751); chk("A_hSync_751", vA.hSync, 0);
    to(752); chk("A_hSync_752", vA.hSync, 1);
    to(799); chk("A_active_799", vA.active, 0);
    to(800); chk("A_line_active", vA.active, 1); chk("A_line_x", vA.x, 0); chk("A_line_y", vA.y, 1);
    to(801); chk("A_x_801", vA.x, 1); chk("A_y_801", vA.y, 1);
    to(874); chk("B_mid_x", vB.x, 4); chk("B_mid_y", vB.y, 3);
    reset = 1'b1;
    @(posedge clk25);
    #1;
    reset = 1'b0;
    cyc = 0;
    chk("B_midrst_x", vB.x, 0);
    chk("B_midrst_y", vB.y, 0);
    chk("B_midrst_active", vB.active, 1);
    chk("A_midrst_x", vA.x, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("B_midrst_fc", vB.frameCount, 0);
`endif
    to(89);  chk("B_midrst_se_89", vB.screenEnd, 0);
    to(90);  chk("B_midrst_se_90", vB.screenEnd, 1);
    @(posedge clk25);
    mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
